// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Two-input round-robin arbiter that merges two valid/ready producers onto one
// valid/ready consumer. A grant is held for bursts of up to BURST_LEN beats,
// then rotates to the other requester. A requester that drops valid while it
// owns the grant gives the grant up early. The output is a single register
// stage, so nothing on the consumer side reaches back into the producers
// except data_out_ready through the ready gating.
//
// Handshake semantics: a beat moves across an interface on a rising clock edge
// where both valid and ready are high. A producer holds valid and its data
// stable until that happens. Ready may depend combinationally on
// data_out_ready and on nothing else.
//
// Parameters
//   DATA_WIDTH      width of every data bus
//   BURST_LEN       beats accepted per grant before forced rotation (1..255)
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   data_in1        requester 1 data
//   data_in1_valid  requester 1 has a beat
//   data_in1_ready  requester 1 beat accepted when valid is also high
//   data_in2        requester 2 data
//   data_in2_valid  requester 2 has a beat
//   data_in2_ready  requester 2 beat accepted when valid is also high
//   data_out        registered output data
//   data_out_valid  output register holds a beat
//   data_out_ready  consumer takes the beat this cycle
//   grant           one-hot owner: 01 input 1, 10 input 2, 00 idle; it is
//                   also the FSM state encoding, so it doubles as the state
//                   debug view
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic                  data_in1_valid,
    output logic                  data_in1_ready,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic                  data_in2_valid,
    output logic                  data_in2_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [1:0]            grant
);

    // State encoding equals the grant vector, so the output decode is trivial.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT1 = 2'b01,
        ST_GRANT2 = 2'b10
    } state_t;

    // Count value at which the accepting transfer completes a burst.
    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

    state_t     state;
    state_t     state_next;

    // prio = 1: input 1 is preferred on a simultaneous request from IDLE.
    // prio = 0: input 2 is preferred.
    logic       prio;
    logic       prio_next;

    logic [7:0] beat_cnt;

    logic       slot_free;
    logic       xfer1;
    logic       xfer2;
    logic       xfer;
    logic       burst_end;
    logic       enter_grant;

    // The output register can take a new beat if it is empty or being drained
    // in this same cycle.
    assign slot_free = !data_out_valid || data_out_ready;

    assign xfer1 = data_in1_valid && data_in1_ready;
    assign xfer2 = data_in2_valid && data_in2_ready;
    assign xfer  = xfer1 || xfer2;

    // Only the owner can transfer, so any transfer hitting the last count
    // closes the owner's burst.
    assign burst_end = xfer && (beat_cnt == BURST_LAST);

    // Entering a grant state (from IDLE or from the other grant) restarts the
    // burst count.
    assign enter_grant = (state_next != ST_IDLE) && (state_next != state);

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            prio  <= 1'b1;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // Leaving a grant, whether by burst end or early release, always hands
    // preference to the other input and goes straight to it if it is waiting,
    // so a burst-end handover costs no bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        prio_next  = prio;
        case (state)
            ST_IDLE: begin
                if (data_in1_valid && data_in2_valid) begin
                    state_next = prio ? ST_GRANT1 : ST_GRANT2;
                end else if (data_in1_valid) begin
                    state_next = ST_GRANT1;
                end else if (data_in2_valid) begin
                    state_next = ST_GRANT2;
                end
            end
            ST_GRANT1: begin
                if (burst_end || !data_in1_valid) begin
                    prio_next  = 1'b0;
                    state_next = data_in2_valid ? ST_GRANT2 : ST_IDLE;
                end
            end
            ST_GRANT2: begin
                if (burst_end || !data_in2_valid) begin
                    prio_next  = 1'b1;
                    state_next = data_in1_valid ? ST_GRANT1 : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs
    // Ready is the owner's slot_free; the only combinational input path is
    // data_out_ready through slot_free.
    // -------------------------------------------------------------------------
    always_comb begin
        data_in1_ready = 1'b0;
        data_in2_ready = 1'b0;
        grant          = state;
        case (state)
            ST_GRANT1: data_in1_ready = slot_free;
            ST_GRANT2: data_in2_ready = slot_free;
            default: begin
                data_in1_ready = 1'b0;
                data_in2_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Burst counter. Stalled cycles leave it alone so a burst interrupted by
    // backpressure resumes where it stopped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 8'd0;
        end else if (enter_grant) begin
            beat_cnt <= 8'd0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output register. A load in the same cycle as a drain overwrites the
    // register and keeps valid high; otherwise a drain empties it. Reset
    // throws away whatever beat is held.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (xfer) begin
            data_out       <= xfer1 ? data_in1 : data_in2;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Embedded properties
    // -------------------------------------------------------------------------
    a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));

    a_ready_exclusive : assert property (
        @(posedge clk) !(data_in1_ready && data_in2_ready));

    a_hold_when_stalled : assert property (
        @(posedge clk) disable iff (rst)
        (data_out_valid && !data_out_ready) |=> $stable(data_out));

    a_count_bounded : assert property (
        @(posedge clk) beat_cnt <= 8'(BURST_LEN));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Two counting producers (value increments by one per accepted beat, a
// remaining-beat count drives valid) feed the arbiter. Each phase pushes the
// output order it expects into exp_q; a negedge monitor pops and compares
// every beat the consumer takes. Cycle-exact grant/valid/ready checks are made
// from the main sequence two time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int DW = 32;

    // ------------------------------------------------------------------ clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ DUT io
    logic          rst;
    logic [DW-1:0] data_in1;
    logic          data_in1_valid;
    logic          data_in1_ready;
    logic [DW-1:0] data_in2;
    logic          data_in2_valid;
    logic          data_in2_ready;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [1:0]    grant;

    stream_rr_arbiter #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in1       (data_in1),
        .data_in1_valid (data_in1_valid),
        .data_in1_ready (data_in1_ready),
        .data_in2       (data_in2),
        .data_in2_valid (data_in2_valid),
        .data_in2_ready (data_in2_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .grant          (grant)
    );

    // ------------------------------------------------------------ bench state
    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            rem1     = 0;
    int            rem2     = 0;
    bit            acc1;
    bit            acc2;

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------- scoreboard
    // Values seen at the negedge are the ones the next rising edge acts on,
    // because the bench only changes inputs just after a rising edge.
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready) begin
            check("sb_has_exp", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("out_data", data_out, exp_q.pop_front());
            end
        end
        acc1 = !rst && data_in1_valid && data_in1_ready;
        acc2 = !rst && data_in2_valid && data_in2_ready;
    end

    // ---------------------------------------------------------------- drivers
    task automatic set_src1(input logic [DW-1:0] start, input int n);
        data_in1       = start;
        rem1           = n;
        data_in1_valid = (rem1 > 0);
    endtask

    task automatic set_src2(input logic [DW-1:0] start, input int n);
        data_in2       = start;
        rem2           = n;
        data_in2_valid = (rem2 > 0);
    endtask

    task automatic push_seq(input logic [DW-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + DW'(i));
        end
    endtask

    // One clock: advance producers whose beat was taken on this edge, then
    // leave time for combinational outputs to settle before any check.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc1) begin
            data_in1 = data_in1 + 1;
            rem1--;
        end
        if (acc2) begin
            data_in2 = data_in2 + 1;
            rem2--;
        end
        data_in1_valid = (rem1 > 0);
        data_in2_valid = (rem2 > 0);
        #1;
    endtask

    // Run until every expected beat has come out and the arbiter is idle,
    // bounded by a cycle budget.
    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || data_out_valid || grant != 2'b00) && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'({data_out_valid, grant}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data_out, 32'd0);
        check({tag, "_valid"}, 32'(data_out_valid), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_rdy"},   32'({data_in1_ready, data_in2_ready}), 32'd0);
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        logic [1:0] g_exp;

        rst            = 1'b1;
        data_out_ready = 1'b1;
        set_src1(32'd1, 12);
        set_src2(32'd101, 12);
        for (int g = 0; g < 3; g++) begin
            push_seq(32'd1 + 32'(4 * g), 4);
            push_seq(32'd101 + 32'(4 * g), 4);
        end

        // Reset held with both inputs requesting and the consumer ready.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_reset_outputs("rst_hold");
        end
        rst = 1'b0;

        // First edge out of reset: input 1 wins on reset priority.
        tick();
        check("rr_first_grant", 32'(grant), 32'b01);
        check("rr_first_rdy", 32'(data_in1_ready), 32'd1);

        // Round robin, one beat per cycle, no gap between groups of four.
        for (int k = 0; k < 24; k++) begin
            g_exp = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
            check("rr_grant", 32'(grant), 32'(g_exp));
            tick();
            check("rr_nogap", 32'(data_out_valid), 32'd1);
        end
        tick();
        check("rr_end_valid", 32'(data_out_valid), 32'd0);
        check("rr_end_grant", 32'(grant), 32'b00);
        wait_drain("rr");

        // Backpressure in the middle of input 1's first burst.
        set_src1(32'd201, 6);
        set_src2(32'd301, 6);
        push_seq(32'd201, 4);
        push_seq(32'd301, 4);
        push_seq(32'd205, 2);
        push_seq(32'd305, 2);
        tick();
        check("bp_grant", 32'(grant), 32'b01);
        tick();
        tick();
        data_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", data_out, 32'd202);
            check("bp_hold_valid", 32'(data_out_valid), 32'd1);
            check("bp_rdy", 32'({data_in1_ready, data_in2_ready}), 32'd0);
            check("bp_grant_kept", 32'(grant), 32'b01);
        end
        data_out_ready = 1'b1;
        wait_drain("bp");

        // Early release: input 1 stops after two beats, input 2 takes over
        // and is cut off after a full burst of four.
        set_src1(32'd401, 2);
        set_src2(32'd501, 6);
        push_seq(32'd401, 2);
        push_seq(32'd501, 6);
        tick();
        check("er_grant1", 32'(grant), 32'b01);
        tick();
        tick();
        check("er_grant1_last", 32'(grant), 32'b01);
        tick();
        check("er_handover", 32'(grant), 32'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("er_burst_end", 32'(grant), 32'b00);
        tick();
        check("er_regrant", 32'(grant), 32'b10);
        check("er_bubble", 32'(data_out_valid), 32'd0);
        wait_drain("er");

        // Single beat on input 1.
        set_src1(32'd666, 1);
        push_seq(32'd666, 1);
        tick();
        check("sb_grant", 32'(grant), 32'b01);
        check("sb_pre_valid", 32'(data_out_valid), 32'd0);
        tick();
        check("sb_data", data_out, 32'd666);
        check("sb_valid", 32'(data_out_valid), 32'd1);
        tick();
        check("sb_post_valid", 32'(data_out_valid), 32'd0);
        check("sb_post_grant", 32'(grant), 32'b00);
        wait_drain("sb");

        // Mid-burst reset. Input 2 is preferred going in; after reset the
        // held beat 702 must vanish and input 1 must be preferred again.
        set_src1(32'd701, 8);
        push_seq(32'd701, 8);
        tick();
        check("mr_grant", 32'(grant), 32'b01);
        tick();
        tick();
        data_out_ready = 1'b0;
        rst            = 1'b1;
        exp_q.delete();
        tick();
        check_reset_outputs("mr_rst");
        rst            = 1'b0;
        data_out_ready = 1'b1;
        set_src2(32'd801, 4);
        push_seq(32'd703, 4);
        push_seq(32'd801, 4);
        push_seq(32'd707, 2);
        tick();
        check("mr_restart_grant", 32'(grant), 32'b01);
        wait_drain("mr");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Two-input round-robin arbiter that shares one valid/ready consumer between two valid/ready producers. It is the merge-side counterpart to the stream splitter in the backpropagation datapath: layer units that must time-share a single downstream FIFO or compute port sit behind it. Grants are held for bursts of up to BURST_LEN beats. The output is a one-entry register stage, so downstream timing is isolated.

## Interface
- DATA_WIDTH, 32: width of every data bus.
- BURST_LEN, 4: maximum beats accepted per grant before forced rotation; legal values are 1 to 255.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in1  in  DATA_WIDTH  requester 1 data.
- data_in1_valid  in  1  requester 1 has a beat.
- data_in1_ready  out  1  requester 1 beat accepted this cycle when valid is also high.
- data_in2  in  DATA_WIDTH  requester 2 data.
- data_in2_valid  in  1  requester 2 has a beat.
- data_in2_ready  out  1  requester 2 beat accepted this cycle when valid is also high.
- data_out  out  DATA_WIDTH  registered output data.
- data_out_valid  out  1  output register holds a beat.
- data_out_ready  in  1  consumer takes the beat this cycle.
- grant  out  2  one-hot current owner: 01 means input 1, 10 means input 2, 00 means idle.

## Operation
- States:
  - IDLE: no ready asserted, grant is 00.
  - GRANT1: only data_in1_ready may assert, grant is 01.
  - GRANT2: only data_in2_ready may assert, grant is 10.
- Register `prio` is 1 bit and names the preferred requester; reset value selects input 1.
- IDLE transitions:
  - If exactly one input is valid, go to that input's GRANT state.
  - If both are valid, go to GRANTprio.
  - If neither is valid, stay in IDLE.
- Output slot free: `slot_free = !data_out_valid || data_out_ready`.
- Ready rule: in GRANTk, `data_ink_ready = slot_free`. This is combinational from data_out_ready; there is no other comb path.
- Transfer: `data_ink_valid && data_ink_ready` loads data_ink into data_out, sets data_out_valid, and increments the beat counter.
- data_out_valid clears when `data_out_ready` is high and no new beat loads in the same cycle.
- The beat counter is 8 bits. It clears on every entry to a GRANT state.
- Leaving GRANTk, with j as the other input:
  - Burst end: a transfer makes the count reach BURST_LEN. Set `prio = j`. Go to GRANTj if data_inj_valid, otherwise go to IDLE.
  - Early release: data_ink_valid is low in any cycle. Set `prio = j`. Go to GRANTj if data_inj_valid, otherwise go to IDLE.
- Backpressure while granted (slot not free, valid high) keeps the state and leaves the count unchanged.
- data_out must not change while `data_out_valid && !data_out_ready`.
- No beat is ever dropped or duplicated outside reset.

## Timing
- Reset values:
  - data_out = 0, data_out_valid = 0.
  - grant = 00, both readies = 0.
  - State is IDLE, count is 0, prio is 1.
- Reset mid-operation discards any beat held in the output register and returns to IDLE on the next edge.
- Latency from IDLE:
  - A valid seen at edge n gives grant at n+1.
  - The first transfer occurs in cycle n+1.
  - data_out_valid is high after edge n+2.
- Throughput: 1 beat/cycle within a grant while data_out_ready is held high.
- A burst-end handover directly to the other input costs no bubble cycle.
- An idle-to-regrant path costs 1 bubble cycle.
- Simultaneous transfer-in and drain-out in one cycle is legal; the register is overwritten with the new beat and data_out_valid stays 1.
- With BURST_LEN = 1 and both inputs valid, grants alternate every beat.

## Test plan
- Reset: hold rst for 5 cycles with both inputs valid and data_out_ready = 1.
  - Required: all outputs stay at reset values.
  - Required: one cycle after rst falls, grant = 01.
- Single beat: data_in1 = 666, valid for 1 cycle, data_out_ready = 1.
  - Required: grant = 01 at n+1.
  - Required: data_out = 666 with data_out_valid high for exactly 1 cycle.
  - Required: grant = 00 afterwards.
- Round-robin (BURST_LEN = 4): both inputs always valid, input 1 streams 1,2,3,...; input 2 streams 101,102,...; data_out_ready = 1.
  - Required: output sequence 1,2,3,4,101,102,103,104,5,...
  - Required: no gap between groups.
- Backpressure: while streaming, drop data_out_ready for 5 cycles.
  - Required: data_out is held and both readies are 0.
  - Required: after release, the sequence continues with no loss or duplication, and the burst count resumes.
- Early release: input 1 sends 2 beats then drops valid while input 2 is valid.
  - Required: grant goes 10 on the next edge.
  - Required: input 2 receives a full 4-beat burst.
- Mid-burst reset: assert rst after beat 2 with data_out_ready = 0.
  - Required: data_out_valid = 0 next cycle and the held beat never appears.
  - Required: arbitration restarts with input 1 preferred.
